// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS32 subset core with one shared ALU.
// The instruction and data memories are external and use req/ready
// handshakes, so any number of wait states is tolerated.
// Ports:
//   clk, rst (async, active low)
//   imem_req/imem_addr/imem_rdata/imem_ready : instruction fetch handshake
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ready : data access
//   pc      : current PC (already points past the word being decoded)
//   halted  : core parked on a HALT word until reset
//   retire  : one-cycle pulse per completed instruction (registered)
//   illegal : one-cycle pulse on unsupported opcode/funct (registered)
module mips_multicycle_core #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic [31:0]     dmem_wdata,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_ready,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            retire,
  output logic            illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;

  state_t      state, state_nx;
  logic [31:0] ir, a, b, alu_out, mdr, imm;
  logic [31:0] rf [32];
  logic        retire_nx, illegal_nx;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        is_r, is_br, is_mem, legal, br_take;
  logic [31:0] alu_res;
  logic [4:0]  wb_dst;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];

  assign is_r   = (op == OP_R);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign wb_dst = is_r ? rd : rt;
  assign br_take = (op == OP_BEQ) ? (a == b) : (a != b);

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  // Shared ALU: R-type by funct, everything else is base + sign-extended imm.
  always_comb begin
    alu_res = a + imm;
    if (is_r) begin
      case (funct)
        6'h20:   alu_res = a + b;
        6'h22:   alu_res = a - b;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
        6'h00:   alu_res = b << shamt;
        6'h02:   alu_res = b >> shamt;
        default: alu_res = a + b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    retire_nx  = 1'b0;
    illegal_nx = 1'b0;
    case (state)
      IDLE:   state_nx = FETCH;
      FETCH:  if (imem_ready) state_nx = DECODE;
      DECODE: begin
        if (op == OP_HALT) state_nx = HALT;
        else if (op == OP_J) begin
          retire_nx = 1'b1;
          state_nx  = FETCH;
        end else if (!legal) begin
          // unsupported words retire as NOPs so software can count them
          retire_nx  = 1'b1;
          illegal_nx = 1'b1;
          state_nx   = FETCH;
        end else state_nx = EXEC;
      end
      EXEC: begin
        if (is_br) begin
          retire_nx = 1'b1;
          state_nx  = FETCH;
        end else if (is_mem) state_nx = MEM;
        else state_nx = WB;
      end
      MEM: begin
        if (dmem_ready) begin
          if (op == OP_SW) begin
            retire_nx = 1'b1;
            state_nx  = FETCH;
          end else state_nx = WB;
        end
      end
      WB: begin
        retire_nx = 1'b1;
        state_nx  = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= PC_W'(RESET_PC);
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retire  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retire  <= retire_nx;
      illegal <= illegal_nx;
      case (state)
        FETCH: if (imem_ready) begin
          ir <= imem_rdata;
          pc <= pc + PC_W'(4);
        end
        DECODE: begin
          a   <= rf[rs];
          b   <= rf[rt];
          imm <= {{16{ir[15]}}, ir[15:0]};
          if (op == OP_J) pc <= PC_W'({ir[25:0], 2'b00});
        end
        EXEC: begin
          alu_out <= alu_res;
          // pc already holds the address of the next word
          if (is_br && br_take) pc <= pc + PC_W'({imm[29:0], 2'b00});
        end
        MEM: if (dmem_ready && op == OP_LW) mdr <= dmem_rdata;
        WB:  if (wb_dst != 5'd0) rf[wb_dst] <= (op == OP_LW) ? mdr : alu_out;
        default: ;
      endcase
    end
  end

  // Requests come straight from state so reset drops them immediately.
  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = alu_out[PC_W-1:0];
  assign dmem_wdata = b;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs run from a bench-side ROM and
// data RAM with programmable wait states. Register contents are observed
// through store data; timing through retire-pulse cycle stamps.
module tb_mips_multicycle_core;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req, imem_ready;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_ready;
  logic [PC_W-1:0] dmem_addr;
  logic [31:0]     dmem_wdata, dmem_rdata;
  logic [PC_W-1:0] pc;
  logic            halted, retire, illegal;

  mips_multicycle_core #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .halted(halted), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int i_wait, d_wait, hcyc;
  logic stall8;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int iw, dw, cyc, ret_cnt, ill_cnt, ill_bad, st_cnt, ld_cnt, fn, unstable;
  int ret_t [32];
  int ftr [32];
  logic [31:0] st_data [16];
  logic [31:0] st_addr [16];
  logic ih, dh, dh_we;
  logic [PC_W-1:0] ih_addr, dh_addr;
  logic [31:0] dh_data;

  assign imem_rdata = imem[imem_addr[7:2]];
  assign imem_ready = imem_req && (iw >= i_wait);
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign dmem_ready = dmem_req && (dw >= d_wait) && !(stall8 && dmem_addr == 8'd8);

  // Memory responders and event logging.
  always @(posedge clk) begin
    if (!rst) begin
      iw <= 0; dw <= 0; cyc <= 0; ret_cnt <= 0; ill_cnt <= 0; ill_bad <= 0;
      st_cnt <= 0; ld_cnt <= 0; fn <= 0; unstable <= 0; ih <= 1'b0; dh <= 1'b0;
      for (int k = 0; k < 64; k++) dmem[k] <= '0;
    end else begin
      cyc <= cyc + 1;
      iw  <= (imem_req && !imem_ready) ? iw + 1 : 0;
      dw  <= (dmem_req && !dmem_ready) ? dw + 1 : 0;
      if (retire) begin
        if (ret_cnt < 32) ret_t[ret_cnt] <= cyc;
        ret_cnt <= ret_cnt + 1;
      end
      if (illegal) begin
        ill_cnt <= ill_cnt + 1;
        if (!retire) ill_bad <= ill_bad + 1;
      end
      if (imem_req && imem_ready) begin
        if (fn < 32) ftr[fn] <= int'(imem_addr);
        fn <= fn + 1;
      end
      if (dmem_req && dmem_ready) begin
        if (dmem_we) begin
          dmem[dmem_addr[7:2]] <= dmem_wdata;
          if (st_cnt < 16) begin
            st_data[st_cnt] <= dmem_wdata;
            st_addr[st_cnt] <= 32'(dmem_addr);
          end
          st_cnt <= st_cnt + 1;
        end else ld_cnt <= ld_cnt + 1;
      end
      ih      <= imem_req && !imem_ready;
      ih_addr <= imem_addr;
      dh      <= dmem_req && !dmem_ready;
      dh_addr <= dmem_addr;
      dh_data <= dmem_wdata;
      dh_we   <= dmem_we;
      if ((ih && (!imem_req || imem_addr != ih_addr)) ||
          (dh && (!dmem_req || dmem_addr != dh_addr || dmem_wdata != dh_data || dmem_we != dh_we)))
        unstable <= unstable + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ri(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int sh, input int fnc);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fnc)};
  endfunction
  function automatic logic [31:0] jj(input int t);
    return {6'h02, 26'(t)};
  endfunction
  localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

  task automatic clr_imem();
    for (int k = 0; k < 64; k++) imem[k] = 32'd0;
  endtask

  task automatic start();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_halt(input int maxc);
    int n = 0;
    while (!halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    hcyc = cyc;
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic load_p1();
    clr_imem();
    imem[0] = ri(8, 0, 1, 5);
    imem[1] = ri(8, 0, 2, -3);
    imem[2] = rr(1, 2, 3, 0, 'h20);
    imem[3] = ri('h2B, 0, 3, 0);
    imem[4] = HALT_W;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_wait = 0; d_wait = 0; stall8 = 1'b0;
    clr_imem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_dmem_we", 32'(dmem_we), 0);
    chk("rst_dmem_addr", 32'(dmem_addr), 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_illegal", 32'(illegal), 0);

    // P1: addi/addi/add/sw/halt, zero-wait
    load_p1();
    start();
    run_halt(200);
    chk("p1_halt_cycle", hcyc, 19);
    chk("p1_pc", 32'(pc), 32'h14);
    chk("p1_ret_cnt", ret_cnt, 4);
    chk("p1_ret0", ret_t[0], 5);
    chk("p1_ret1", ret_t[1], 9);
    chk("p1_ret2", ret_t[2], 13);
    chk("p1_ret3", ret_t[3], 17);
    chk("p1_st_cnt", st_cnt, 1);
    chk("p1_st_addr", st_addr[0], 0);
    chk("p1_r3", st_data[0], 2);
    repeat (5) @(negedge clk);
    chk("p1_halt_noret", ret_cnt, 4);
    chk("p1_halt_pc", 32'(pc), 32'h14);
    chk("p1_halt_noreq", 32'(imem_req), 0);

    // P1 again with 3 wait states per fetch
    i_wait = 3;
    start();
    run_halt(300);
    chk("p1w_halt_cycle", hcyc, 34);
    chk("p1w_ret0", ret_t[0], 8);
    chk("p1w_ret1", ret_t[1], 15);
    chk("p1w_ret3", ret_t[3], 29);
    chk("p1w_r3", st_data[0], 2);
    chk("p1w_stable", unstable, 0);
    chk("p1w_pc", 32'(pc), 32'h14);

    // P2: build 0xDEADBEEF, sw/lw/sw through a 2-wait dmem
    i_wait = 0; d_wait = 2;
    clr_imem();
    imem[0] = ri(8, 0, 1, 'hDEAD);
    imem[1] = rr(0, 1, 1, 16, 'h00);
    imem[2] = ri(8, 0, 2, 'hBEEF);
    imem[3] = rr(0, 2, 2, 16, 'h00);
    imem[4] = rr(0, 2, 2, 16, 'h02);
    imem[5] = rr(1, 2, 1, 0, 'h25);
    imem[6] = ri('h2B, 0, 1, 8);
    imem[7] = ri('h23, 0, 4, 8);
    imem[8] = ri('h2B, 0, 4, 12);
    imem[9] = HALT_W;
    start();
    run_halt(300);
    chk("p2_st_cnt", st_cnt, 2);
    chk("p2_ld_cnt", ld_cnt, 1);
    chk("p2_st0_addr", st_addr[0], 8);
    chk("p2_st0_data", st_data[0], 32'hDEADBEEF);
    chk("p2_st1_addr", st_addr[1], 12);
    chk("p2_lw_data", st_data[1], 32'hDEADBEEF);
    chk("p2_sw_lat", ret_t[6] - ret_t[5], 6);
    chk("p2_lw_lat", ret_t[7] - ret_t[6], 7);
    chk("p2_stable", unstable, 0);

    // P3: sub/and/slt, $0 write discard, illegal opcode and funct
    d_wait = 0;
    clr_imem();
    imem[0]  = ri(8, 0, 1, 5);
    imem[1]  = ri(8, 0, 2, -3);
    imem[2]  = rr(1, 2, 3, 0, 'h22);
    imem[3]  = rr(1, 2, 4, 0, 'h24);
    imem[4]  = rr(2, 1, 5, 0, 'h2A);
    imem[5]  = rr(1, 2, 6, 0, 'h2A);
    imem[6]  = ri(8, 0, 0, 7);
    imem[7]  = rr(0, 0, 7, 0, 'h20);
    imem[8]  = {6'h3E, 26'd0};
    imem[9]  = rr(1, 2, 8, 0, 'h21);
    for (int k = 0; k < 6; k++) imem[10+k] = ri('h2B, 0, 3 + k, 4 * k);
    imem[16] = HALT_W;
    start();
    run_halt(300);
    chk("p3_sub", st_data[0], 8);
    chk("p3_and", st_data[1], 5);
    chk("p3_slt_t", st_data[2], 1);
    chk("p3_slt_f", st_data[3], 0);
    chk("p3_r0_zero", st_data[4], 0);
    chk("p3_bad_funct_nowr", st_data[5], 0);
    chk("p3_ill_cnt", ill_cnt, 2);
    chk("p3_ill_with_ret", ill_bad, 0);
    chk("p3_ret_cnt", ret_cnt, 16);
    chk("p3_ill_lat", ret_t[8] - ret_t[7], 2);
    chk("p3_after_ill", ftr[9], 32'h24);

    // P4: bne not taken, j to 0xFC, wrap, bne taken, beq self-loop
    clr_imem();
    imem[0]  = ri(5, 1, 0, 6);
    imem[1]  = ri(8, 0, 1, 1);
    imem[2]  = jj('h3F);
    imem[63] = ri(8, 0, 2, 9);
    imem[7]  = ri('h2B, 0, 2, 0);
    imem[8]  = ri(4, 0, 0, -1);
    start();
    begin
      int n = 0;
      while (fn < 10 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("p4_fetch_cnt", 32'(fn >= 10), 1);
    chk("p4_f0", ftr[0], 32'h00);
    chk("p4_f1", ftr[1], 32'h04);
    chk("p4_f2", ftr[2], 32'h08);
    chk("p4_f3_jump", ftr[3], 32'hFC);
    chk("p4_f4_wrap", ftr[4], 32'h00);
    chk("p4_f5_bne", ftr[5], 32'h1C);
    chk("p4_f6", ftr[6], 32'h20);
    chk("p4_f7_loop", ftr[7], 32'h20);
    chk("p4_f8_loop", ftr[8], 32'h20);
    chk("p4_st", st_data[0], 9);
    chk("p4_bne_nt_lat", ret_t[0], 4);
    chk("p4_addi_ret", ret_t[1], 8);
    chk("p4_j_ret", ret_t[2], 10);
    chk("p4_bne_t_lat", ret_t[4] - ret_t[3], 3);
    chk("p4_beq_lat", ret_t[7] - ret_t[6], 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (imem_req) chk("p4_loop_addr", 32'(imem_addr), 32'h20);
    end

    // P5: reset in the middle of a stalled store
    stall8 = 1'b1;
    clr_imem();
    imem[0] = ri('h2B, 0, 1, 4);
    imem[1] = ri(8, 0, 1, 5);
    imem[2] = ri('h2B, 0, 1, 8);
    imem[3] = HALT_W;
    start();
    begin
      int n = 0;
      while (!(dmem_req && dmem_addr == 8'd8) && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("p5_in_mem", 32'(dmem_req), 1);
    repeat (2) @(negedge clk);
    chk("p5_pre_st_cnt", st_cnt, 1);
    chk("p5_pre_st0", st_data[0], 0);
    #2 rst = 1'b0;
    #1;
    chk("p5_rst_dreq", 32'(dmem_req), 0);
    chk("p5_rst_ireq", 32'(imem_req), 0);
    chk("p5_rst_pc", 32'(pc), 0);
    stall8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("p5_idle", 32'(imem_req), 0);
    @(negedge clk);
    chk("p5_fetch_req", 32'(imem_req), 1);
    chk("p5_fetch_addr", 32'(imem_addr), 0);
    run_halt(200);
    chk("p5_st_cnt", st_cnt, 2);
    chk("p5_reg_cleared", st_data[0], 0);
    chk("p5_st1", st_data[1], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
